updown_counter_mod: RTL

Parametrised up/down counter generalising the team's 4-bit up/down counter: configurable width and modulus, wrap or saturate mode, synchronous parallel load, count enable with a built-in prescaler, and registered carry/borrow pulses. It is the standard event/position counter for the sequential-counter family and drives cascaded stages or downstream timers.

---
 rtl/counter_pkg.sv | 32 +++
 rtl/updown_counter_mod_if.sv | 23 ++
 rtl/count_prescaler.sv | 29 ++
 rtl/updown_counter_mod.sv | 89 ++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the sequential-counter family:
// mode constants, sizing helper and parameter legality check.
package counter_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // Ceiling log2, never below 1 so a register always has a bit.
    function automatic int clog2(input longint v);
        int r;
        longint x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit params_ok(
        input int     width,
        input longint modulus,
        input longint prescale
    );
        return (width >= 1) && (width <= 32) &&
               (modulus >= 2) &&
               (modulus <= (longint'(1) << width)) &&
               (prescale >= 1) && (prescale <= 65536);
    endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle of the up/down counter.
// master drives the controls, slave is the counter.
interface updown_counter_mod_if #(
    parameter int WIDTH = 4
);
    logic             En;
    logic             UD;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] Count;
    logic             Carry;
    logic             Borrow;

    modport master (
        output En, UD, Load, LoadVal,
        input  Count, Carry, Borrow
    );

    modport slave (
        input  En, UD, Load, LoadVal,
        output Count, Carry, Borrow
    );
endinterface

// File: rtl/count_prescaler.sv
// Modulo-PRESCALE enable divider; Tick is combinational.
// With PRESCALE=1 the register is constant 0 and Tick=En.
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic Clear,
    input  logic En,
    input  logic Restart,
    output logic Tick
);
    localparam int PW = clog2(longint'(PRESCALE));
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (Clear || Restart) begin
            cnt <= '0;
        end else if (En) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

    assign Tick = En && (cnt == LAST);

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus, wrap/saturate,
// parallel load, prescaled enable and registered carry/borrow.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = CNT_WRAP,
    parameter int     PRESCALE = 1
) (
    input  logic                  CLK,
    input  logic                  Clear,
    updown_counter_mod_if.slave   bus
);
    if (!params_ok(WIDTH, MODULUS, longint'(PRESCALE))) begin : g_bad
        $error("updown_counter_mod: illegal parameters");
    end

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic             tick;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             carry_q;
    logic             carry_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             at_top;
    logic             at_zero;
    logic [WIDTH-1:0] load_v;

    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .CLK     (CLK),
        .Clear   (Clear),
        .En      (bus.En),
        .Restart (bus.Load),
        .Tick    (tick)
    );

    assign at_top  = (count_q == TOP);
    assign at_zero = (count_q == '0);
    assign load_v  = (bus.LoadVal > TOP) ? TOP : bus.LoadVal;

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        unique case (1'b1)
            (tick && bus.UD && at_top): begin
                carry_d = 1'b1;
                count_d = (SATURATE == CNT_SAT) ? TOP : '0;
            end
            (tick && bus.UD && !at_top): begin
                count_d = count_q + WIDTH'(1);
            end
            (tick && !bus.UD && at_zero): begin
                borrow_d = 1'b1;
                count_d  = (SATURATE == CNT_SAT) ? '0 : TOP;
            end
            (tick && !bus.UD && !at_zero): begin
                count_d = count_q - WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else if (bus.Load) begin
            count_q  <= load_v;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.Count  = count_q;
    assign bus.Carry  = carry_q;
    assign bus.Borrow = borrow_q;

endmodule
